// File: rtl/miner_work_ctrl_if.sv
// -----------------------------------------------------------------------------
// miner_work_ctrl_if
// Host-side channels of the miner work controller.
//   work_*  : host offers new work (valid/ready), midstate/data/nonce2 limit
//   res_*   : golden-nonce result stream (valid/ready, first-word fall-through)
// Modports:
//   master : host side (drives work offer, consumes results)
//   slave  : controller side
// Handshake rule for both channels: a transfer happens on the rising clk edge
// where valid & ready are both 1; the sender holds its payload stable while
// valid is 1 and ready is 0; ready may depend on state but never on valid.
// -----------------------------------------------------------------------------
interface miner_work_ctrl_if;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [31:0]  work_limit;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_nonce;

    modport master (
        output work_valid, work_midstate, work_data, work_limit, res_ready,
        input  work_ready, res_valid, res_nonce
    );

    modport slave (
        input  work_valid, work_midstate, work_data, work_limit, res_ready,
        output work_ready, res_valid, res_nonce
    );
endinterface

// File: rtl/miner_work_ctrl.sv
// -----------------------------------------------------------------------------
// miner_work_ctrl
// Sequences one double-hash miner core: accepts work from the host, loads it
// into the core while pulsing the core reset, watches nonce2 for range
// exhaustion and captures golden nonces into a small result FIFO.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   host (slave)         : work offer channel and result channel
//   miner_reset          : active-high reset to the core (1 unless RUN)
//   miner_midstate/data  : registered work payload to the core
//   miner_golden_nonce   : core golden nonce register
//   miner_nonce2         : core current nonce2
//   busy / exhausted     : state is LOAD|RUN / state is EXHAUSTED
//   overflow             : sticky, a golden nonce was dropped (FIFO full)
//   dbg_state            : current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 EXH)
// -----------------------------------------------------------------------------
module miner_work_ctrl #(
    parameter int          RST_CYCLES    = 4,
    parameter int          SETTLE_CYCLES = 300,
    parameter logic [31:0] GOLDEN_ADJ    = 32'd0,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    miner_work_ctrl_if.slave        host,
    output logic                    miner_reset,
    output logic [255:0]            miner_midstate,
    output logic [95:0]             miner_data,
    input  logic [31:0]             miner_golden_nonce,
    input  logic [31:0]             miner_nonce2,
    output logic                    busy,
    output logic                    exhausted,
    output logic                    overflow,
    output logic [1:0]              dbg_state
);
    localparam int RCW = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_EXH  = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [RCW-1:0] rst_cnt;
    logic [SCW-1:0] settle_cnt;
    logic [31:0]    limit;
    logic [31:0]    prev_golden;

    logic [31:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;

    logic accept, push, pop, full, wr_en;

    assign accept = host.work_valid & host.work_ready;

    // State-derived outputs.
    assign host.work_ready = (state != ST_LOAD);
    assign miner_reset     = (state != ST_RUN);
    assign busy            = (state == ST_LOAD) || (state == ST_RUN);
    assign exhausted       = (state == ST_EXH);
    assign dbg_state       = state;

    // Next-state logic; new work in RUN wins over exhaustion.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_LOAD;
            ST_LOAD: if (rst_cnt == '0) state_n = ST_RUN;
            ST_RUN: begin
                if (accept)
                    state_n = ST_LOAD;
                else if (settle_cnt == '0 && miner_nonce2 >= limit)
                    state_n = ST_EXH;
            end
            ST_EXH:  if (accept) state_n = ST_LOAD;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Work latch, LOAD length counter and post-load settle window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miner_midstate <= '0;
            miner_data     <= '0;
            limit          <= '0;
            rst_cnt        <= '0;
            settle_cnt     <= '0;
        end else begin
            if (accept) begin
                miner_midstate <= host.work_midstate;
                miner_data     <= host.work_data;
                limit          <= host.work_limit;
                rst_cnt        <= RCW'(RST_CYCLES - 1);
            end else if (state == ST_LOAD && rst_cnt != '0) begin
                rst_cnt <= rst_cnt - 1'b1;
            end
            // Reloaded throughout LOAD so RUN always starts with a full window.
            if (state == ST_LOAD)
                settle_cnt <= SCW'(SETTLE_CYCLES);
            else if (state == ST_RUN && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;
        end
    end

    // Golden capture: the core reset clears its golden register, so the
    // comparison reference is forced to 0 while loading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                prev_golden <= '0;
        else if (state == ST_LOAD) prev_golden <= '0;
        else if (state == ST_RUN)  prev_golden <= miner_golden_nonce;
    end

    assign push  = (state == ST_RUN) && (miner_golden_nonce != prev_golden);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign pop   = host.res_valid & host.res_ready;
    // A pop in the same cycle frees the slot being written when full.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= miner_golden_nonce - GOLDEN_ADJ;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept)
                overflow <= 1'b0;
            else if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    assign host.res_valid = (count != '0);
    assign host.res_nonce = mem[rd_ptr];

endmodule

// File: tb/tb_miner_work_ctrl.sv
module tb_miner_work_ctrl;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_EXH  = 2'd3;

    logic         clk;
    logic         reset;
    logic         miner_reset;
    logic [255:0] miner_midstate;
    logic [95:0]  miner_data;
    logic [31:0]  miner_golden_nonce;
    logic [31:0]  miner_nonce2;
    logic         busy, exhausted, overflow;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    miner_work_ctrl_if bus();

    miner_work_ctrl #(
        .RST_CYCLES(4), .SETTLE_CYCLES(300), .GOLDEN_ADJ(32'd2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .host(bus),
        .miner_reset(miner_reset), .miner_midstate(miner_midstate),
        .miner_data(miner_data), .miner_golden_nonce(miner_golden_nonce),
        .miner_nonce2(miner_nonce2), .busy(busy), .exhausted(exhausted),
        .overflow(overflow), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer_work(input logic [255:0] ms, input logic [95:0] d, input logic [31:0] lim);
        bus.work_valid    = 1'b1;
        bus.work_midstate = ms;
        bus.work_data     = d;
        bus.work_limit    = lim;
        tick();
        bus.work_valid    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.work_valid = 1'b0; bus.work_midstate = '0; bus.work_data = '0;
        bus.work_limit = '0; bus.res_ready = 1'b0;
        miner_golden_nonce = '0; miner_nonce2 = '0;
        tick(2);
        checks++; if (miner_reset !== 1'b1) begin errors++; $display("FAIL reset_miner_reset got %b exp 1", miner_reset); end
        checks++; if (miner_midstate !== 256'd0) begin errors++; $display("FAIL reset_midstate got %h exp 0", miner_midstate); end
        checks++; if (miner_data !== 96'd0) begin errors++; $display("FAIL reset_data got %h exp 0", miner_data); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", bus.res_valid); end
        checks++; if (overflow !== 1'b0 || busy !== 1'b0 || exhausted !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b busy=%b exh=%b exp 0,0,0", overflow, busy, exhausted); end
        checks++; if (dbg_state !== S_IDLE || bus.work_ready !== 1'b1) begin errors++; $display("FAIL reset_state got st=%0d rdy=%b exp 0,1", dbg_state, bus.work_ready); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load();
        logic [255:0] ms;
        ms = {8{32'h11111111}};
        offer_work(ms, 96'hABCDEF, 32'h100);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.work_ready !== 1'b0 || miner_reset !== 1'b1 || busy !== 1'b1 || dbg_state !== S_LOAD) begin
                errors++; $display("FAIL load_cycle%0d got rdy=%b mrst=%b busy=%b st=%0d exp 0,1,1,1", i, bus.work_ready, miner_reset, busy, dbg_state);
            end
            tick();
        end
        checks++; if (dbg_state !== S_RUN || miner_reset !== 1'b0 || busy !== 1'b1 || bus.work_ready !== 1'b1) begin
            errors++; $display("FAIL load_to_run got st=%0d mrst=%b busy=%b rdy=%b exp 2,0,1,1", dbg_state, miner_reset, busy, bus.work_ready);
        end
        checks++; if (miner_midstate !== ms || miner_data !== 96'hABCDEF) begin errors++; $display("FAIL load_payload got %h exp %h", miner_midstate, ms); end
    endtask

    task automatic test_golden();
        miner_golden_nonce = 32'h1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL golden_not_early got %b exp 0", bus.res_valid); end
        tick(2);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_nonce !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL golden_adjusted got v=%b n=%h exp 1,ffffffff", bus.res_valid, bus.res_nonce);
        end
        tick(50);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL golden_single_push got %b exp 0", bus.res_valid); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL golden_pop_empty got %b exp 0", bus.res_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] vals [5];
        logic [31:0] exp_v;
        vals = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
        for (int i = 0; i < 5; i++) begin
            miner_golden_nonce = vals[i];
            tick();
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (bus.res_valid !== 1'b1 || bus.res_nonce !== 32'd8) begin errors++; $display("FAIL ovf_head got v=%b n=%h exp 1,8", bus.res_valid, bus.res_nonce); end
        miner_golden_nonce = 32'd0;
        offer_work({8{32'h22222222}}, 96'h5, 32'h100);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_v = vals[i] - 32'd2;
            checks++; if (bus.res_valid !== 1'b1 || bus.res_nonce !== exp_v) begin
                errors++; $display("FAIL ovf_pop%0d got v=%b n=%h exp 1,%h", i, bus.res_valid, bus.res_nonce, exp_v);
            end
            tick();
        end
        bus.res_ready = 1'b0;
        checks++; if (bus.res_valid !== 1'b0 || dbg_state !== S_RUN) begin errors++; $display("FAIL ovf_drained got v=%b st=%0d exp 0,2", bus.res_valid, dbg_state); end
        checks++; if (miner_midstate !== {8{32'h22222222}}) begin errors++; $display("FAIL ovf_new_midstate got %h", miner_midstate); end
    endtask

    task automatic test_back_to_back();
        tick(305);
        miner_nonce2 = 32'h200;
        bus.work_valid = 1'b1; bus.work_midstate = {8{32'h33333333}}; bus.work_limit = 32'h100;
        tick();
        miner_nonce2 = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (dbg_state !== S_LOAD || exhausted !== 1'b0) begin
                errors++; $display("FAIL b2b_load%0d got st=%0d exh=%b exp 1,0", i, dbg_state, exhausted);
            end
            tick();
        end
        checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL b2b_run got %0d exp 2", dbg_state); end
        tick();
        checks++; if (dbg_state !== S_LOAD) begin errors++; $display("FAIL b2b_reaccept got %0d exp 1", dbg_state); end
        bus.work_valid = 1'b0;
        tick(4);
    endtask

    task automatic test_exhaust();
        miner_nonce2 = 32'h100;
        tick(10);
        checks++; if (dbg_state !== S_RUN || exhausted !== 1'b0) begin errors++; $display("FAIL exh_settle got st=%0d exh=%b exp 2,0", dbg_state, exhausted); end
        miner_nonce2 = 32'hFF;
        tick(300);
        checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL exh_below_limit got %0d exp 2", dbg_state); end
        miner_nonce2 = 32'h100;
        tick();
        checks++; if (exhausted !== 1'b1 || miner_reset !== 1'b1 || busy !== 1'b0 || bus.work_ready !== 1'b1) begin
            errors++; $display("FAIL exh_enter got exh=%b mrst=%b busy=%b rdy=%b exp 1,1,0,1", exhausted, miner_reset, busy, bus.work_ready);
        end
        miner_nonce2 = 32'h0;
        tick(3);
        checks++; if (dbg_state !== S_EXH) begin errors++; $display("FAIL exh_hold got %0d exp 3", dbg_state); end
        offer_work({8{32'h44444444}}, 96'h7, 32'h100);
        checks++; if (dbg_state !== S_LOAD) begin errors++; $display("FAIL exh_leave got %0d exp 1", dbg_state); end
        tick(4);
    endtask

    task automatic test_async_reset();
        miner_golden_nonce = 32'd7;
        tick();
        miner_golden_nonce = 32'd9;
        tick(2);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_nonce !== 32'd5) begin errors++; $display("FAIL arst_pre got v=%b n=%h exp 1,5", bus.res_valid, bus.res_nonce); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.res_valid !== 1'b0 || miner_reset !== 1'b1 || dbg_state !== S_IDLE) begin
            errors++; $display("FAIL arst_now got v=%b mrst=%b st=%0d exp 0,1,0", bus.res_valid, miner_reset, dbg_state);
        end
        checks++; if (miner_midstate !== 256'd0 || busy !== 1'b0 || overflow !== 1'b0 || bus.work_ready !== 1'b1) begin
            errors++; $display("FAIL arst_outputs got busy=%b ovf=%b rdy=%b ms=%h", busy, overflow, bus.work_ready, miner_midstate);
        end
        tick();
        reset = 1'b1;
        tick(2);
        checks++; if (bus.res_valid !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL arst_after got v=%b st=%0d exp 0,0", bus.res_valid, dbg_state); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_golden();
        test_overflow();
        test_back_to_back();
        test_exhaust();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/miner_work_ctrl.md
Name: miner_work_ctrl

Overview:
- Sequences one double-hash miner core: accepts new work from the host side, loads it into the core and pulses the core's active-high reset.
- Tracks nonce-range exhaustion and captures golden nonces into a small result FIFO with a valid/ready output.
- Sits between the host/USB register interface and the miner core instance.

Parameters:
RST_CYCLES, 4, cycles miner_reset is held high per work load (>=2)
SETTLE_CYCLES, 300, cycles after load during which nonce2 is not checked for exhaustion (> one 260-cycle feedback period)
GOLDEN_ADJ, 32'd0, constant subtracted (mod 2^32) from captured golden nonce to compensate pipeline offset
FIFO_DEPTH, 4, result FIFO entries (power of two, 2..16)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low; 0 = reset
work_valid  in  1  host offers new work
work_ready  out  1  controller can accept work (0 only in LOAD)
work_midstate  in  256  midstate of offered work
work_data  in  96  tail data of offered work
work_limit  in  32  last nonce2 value of range; reaching it means exhausted
miner_reset  out  1  active-high synchronous reset to core
miner_midstate  out  256  registered midstate to core
miner_data  out  96  registered data to core
miner_golden_nonce  in  32  core golden nonce register
miner_nonce2  in  32  core current nonce2
res_valid  out  1  FIFO non-empty
res_ready  in  1  consumer pops when res_valid & res_ready
res_nonce  out  32  FIFO head (adjusted golden nonce)
busy  out  1  state is LOAD or RUN
exhausted  out  1  state is EXHAUSTED
overflow  out  1  sticky: a golden nonce was dropped because FIFO full

Behaviour:
- Reset (reset=0): state IDLE. miner_reset=1, miner_midstate/miner_data=0, FIFO empty, res_valid=0, overflow=0. Internal prev_golden=0, counters=0.
- Work accept: handshake on the clk edge with work_valid & work_ready. Latch midstate, data and limit. Clear overflow. Go to LOAD. The FIFO is NOT flushed.
- work_ready=1 in IDLE, RUN and EXHAUSTED.
- LOAD: miner_reset=1 for exactly RST_CYCLES cycles, starting the cycle after accept. prev_golden is forced to 0. No FIFO pushes. Then go to RUN with settle counter=SETTLE_CYCLES.
- RUN: miner_reset=0. Settle counter decrements to 0 and saturates.
  - Exhaustion: when settle counter==0 and miner_nonce2 >= limit (unsigned), go to EXHAUSTED on the next edge.
  - New work accepted in RUN goes to LOAD. This takes priority over exhaustion in the same cycle.
- EXHAUSTED: miner_reset=1 (core idles), exhausted=1. Leaves only via work accept, to LOAD.
- IDLE: miner_reset=1.
- Golden capture (RUN only, any settle value):
  - Each cycle, sample miner_golden_nonce into prev_golden.
  - If the sample differs from prev_golden, push miner_golden_nonce - GOLDEN_ADJ (32-bit wrap).
  - Push lands 1 cycle after the change is visible; res_valid rises the following cycle at earliest.
- FIFO: first-word fall-through; res_nonce valid whenever res_valid=1.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push when full with no pop: value dropped, overflow=1 (sticky until next work accept or reset).
  - Pop when empty is ignored.
- Reset asserted mid-operation: immediate return to reset values, including FIFO contents lost.
- miner_midstate/miner_data change only on work accept. They are stable during LOAD, RUN and EXHAUSTED.

Test Plan:
1. Reset released, work_valid pulse with midstate=256'h11..., limit=32'h100 -> work_ready=0 for 4 cycles, miner_reset=1 for exactly 4 cycles, then busy=1 and miner_midstate equals the offered value.
2. In RUN after settle, drive miner_nonce2 from 32'hFF to 32'h100 -> exhausted=1 next cycle, miner_reset=1, busy=0. Nonce2=32'h100 during settle window has no effect.
3. With GOLDEN_ADJ=32'd2: golden goes 0 -> 32'h00000001 -> res_nonce=32'hFFFFFFFF, res_valid=1. The same value held for 50 cycles pushes only once.
4. FIFO_DEPTH=4, res_ready=0, five distinct golden changes -> four entries held in order, overflow=1. A new work accept clears overflow and the four entries still pop in order.
5. work_valid in the same cycle as nonce2>=limit in RUN -> LOAD entered, exhausted stays 0. work_valid held during LOAD is not accepted until RUN.
6. Assert reset low mid-RUN with 2 FIFO entries -> res_valid=0, miner_reset=1, state IDLE, all outputs at reset values within the same cycle.
